switch_bank: RTL and testbench
==============================

SWITCH_BANK -- requirements
Module: switch_bank

Interface
REQ-001 SHALL provide parameter UUID, default 0, instance identifier XORed into child identifiers.
REQ-002 SHALL provide parameter NAME, default "", instance label.
REQ-003 SHALL provide parameter WIDTH, default 8, data bits per channel (1..64).
REQ-004 SHALL provide parameter CHANNELS, default 4, channel count (1..16).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_data  input  CHANNELS*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port en  input  CHANNELS  per-channel enable, bit k for channel k.
REQ-009 SHALL have port mode  input  2  0=GATE, 1=HOLD, 2=TOGGLE, 3=SOLO.
REQ-010 SHALL have port clear  input  1  synchronous clear of all channel state.
REQ-011 SHALL have port out_data  output  CHANNELS*WIDTH  registered per-channel data, same packing as in_data.
REQ-012 SHALL have port out_valid  output  CHANNELS  registered per-channel "driven" flag.
REQ-013 SHALL have port bus_data  output  WIDTH  merged bus value.
REQ-014 SHALL have port bus_valid  output  1  at least one channel driven.
REQ-015 SHALL have port conflict  output  1  two or more channels driven.

Function
REQ-016 out_data/out_valid SHALL be registered; latency from in_data/en to outputs is exactly 1 clk.
REQ-017 A channel with out_valid=0 SHALL present out_data=0 (models undriven output).
REQ-018 GATE: each edge, valid_k <= en_k; data_k <= en_k ? in_k : 0.
REQ-019 HOLD: en_k=1 -> data_k <= in_k, valid_k <= 1; en_k=0 -> data_k, valid_k retained.
REQ-020 TOGGLE: registered en_prev per channel; en_k & ~en_prev_k at an edge flips state_k; held-high en SHALL NOT re-toggle.
REQ-021 TOGGLE: after the edge, state_k=1 -> data_k <= in_k, valid_k <= 1; state_k=0 -> data_k <= 0, valid_k <= 0 (new state applies in the toggling edge).
REQ-022 SOLO: as GATE but only the lowest-index channel with en=1 is driven; all others valid=0, data=0.
REQ-023 Registered mode_q; at an edge where mode != mode_q: all data, valid, state SHALL clear, mode_q <= mode, en/in ignored that edge.
REQ-024 en_prev SHALL update every edge regardless of mode, mode change or clear.
REQ-025 clear=1 SHALL zero data, valid, state at the edge; clear has priority over mode-change flush and all mode behaviour; mode_q still updates.
REQ-026 bus_data SHALL equal out_data of the lowest-index channel with out_valid=1, else 0; combinational from registers only.
REQ-027 bus_valid = |out_valid; conflict = (popcount(out_valid) >= 2); no input-to-output combinational path.
REQ-028 CHANNELS=1 SHALL be supported; conflict then constantly 0.

Reset
REQ-029 rst=0 SHALL asynchronously force data, valid, state, en_prev to 0 and mode_q to 0 (GATE).
REQ-030 All outputs SHALL read 0 while rst=0 and until the first edge after release.
REQ-031 If mode != 0 at first edge after release, that edge SHALL be a mode-change flush (REQ-023).
REQ-032 Reset asserted mid-operation SHALL discard all held and toggle state; no state survives.

Verification
REQ-033 GATE, WIDTH=8, CHANNELS=4: en=4'b0101, in ch0=0x11, ch2=0x33 -> next cycle out_valid=0101, bus_data=0x11, conflict=1.
REQ-034 HOLD: en0 pulse 1 cycle with in0=0xA5, then in0=0xFF, en0=0 -> out0 stays 0xA5, valid0=1 until clear; clear -> all 0 next cycle.
REQ-035 TOGGLE: en1 high 3 cycles, low 2, high 1 -> valid1 sets on first rising edge, stays through the low, clears on second rising edge; out1 tracks in1 while set.
REQ-036 SOLO: en=4'b1110 -> only ch1 valid, bus_valid=1, conflict=0; then mode 3->1 with en=1111 -> flush cycle all 0, HOLD captures from following edge.
REQ-037 Assert rst low while HOLD holds 0x5A and TOGGLE-independent state set -> outputs 0 immediately (no clock); release with mode=2 -> first edge flushes, no spurious toggle from en held high.

Source files
------------

// File: rtl/switch_bank.sv
// Bank of CHANNELS output registers with four drive disciplines (gate, hold, toggle, solo)
// and a priority-merged bus view; a mode change or clear flushes every channel.
module switch_bank #(
  parameter int UUID     = 0,
  parameter     NAME     = "",
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       en,
  input  logic [1:0]                mode,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [WIDTH-1:0]          bus_data,
  output logic                      bus_valid,
  output logic                      conflict
);

  typedef enum logic [1:0] {
    MODE_GATE   = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_TOGGLE = 2'd2,
    MODE_SOLO   = 2'd3
  } mode_t;

  if (WIDTH < 1 || WIDTH > 64 || CHANNELS < 1 || CHANNELS > 16) begin : g_bad_params
    $error("switch_bank %s (UUID %0d): WIDTH or CHANNELS out of range", NAME, UUID);
  end

  mode_t                r_mode_q;
  mode_t                w_mode_in;
  logic                 w_flush;
  logic [CHANNELS-1:0]  w_solo_sel;
  logic [WIDTH-1:0]     w_bus_data;

  assign w_mode_in = mode_t'(mode);
  assign w_flush   = clear || (w_mode_in != r_mode_q);

  // Isolate the lowest set enable bit (x & -x).
  assign w_solo_sel = en & (~en + CHANNELS'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode_q <= MODE_GATE;
    end else begin
      r_mode_q <= w_mode_in;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_state;
    logic             r_en_prev;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_data_next;
    logic             w_valid_next;
    logic             w_state_next;
    logic             w_rise;

    assign w_in   = in_data[gi*WIDTH +: WIDTH];
    assign w_rise = en[gi] & ~r_en_prev;

    always_comb begin
      w_data_next  = r_data;
      w_valid_next = r_valid;
      w_state_next = r_state;
      if (w_flush) begin
        w_data_next  = '0;
        w_valid_next = 1'b0;
        w_state_next = 1'b0;
      end else begin
        case (w_mode_in)
          MODE_GATE: begin
            w_valid_next = en[gi];
            w_data_next  = en[gi] ? w_in : '0;
          end
          MODE_HOLD: begin
            if (en[gi]) begin
              w_valid_next = 1'b1;
              w_data_next  = w_in;
            end
          end
          MODE_TOGGLE: begin
            // The flipped state takes effect in the same edge that flips it.
            w_state_next = r_state ^ w_rise;
            w_valid_next = w_state_next;
            w_data_next  = w_state_next ? w_in : '0;
          end
          MODE_SOLO: begin
            w_valid_next = w_solo_sel[gi];
            w_data_next  = w_solo_sel[gi] ? w_in : '0;
          end
          default: begin
            w_valid_next = 1'b0;
            w_data_next  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_data    <= '0;
        r_valid   <= 1'b0;
        r_state   <= 1'b0;
        r_en_prev <= 1'b0;
      end else begin
        r_data    <= w_data_next;
        r_valid   <= w_valid_next;
        r_state   <= w_state_next;
        r_en_prev <= en[gi];
      end
    end

    assign out_data[gi*WIDTH +: WIDTH] = r_data;
    assign out_valid[gi]               = r_valid;
  end

  // Walk from the top so the lowest-index driven channel wins.
  always_comb begin
    w_bus_data = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (out_valid[k]) begin
        w_bus_data = out_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign bus_data  = w_bus_data;
  assign bus_valid = |out_valid;
  assign conflict  = |(out_valid & (out_valid - CHANNELS'(1)));

endmodule

// File: tb/tb_switch_bank.sv
// Directed bench for switch_bank: a per-channel reference model checked every cycle,
// plus literal expectations for the worked scenarios; a one-channel instance rides along.
module tb_switch_bank;

  localparam int W  = 8;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0] en;
  logic [1:0]    mode;
  logic          clear;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0] out_valid;
  logic [W-1:0]  bus_data;
  logic          bus_valid;
  logic          conflict;

  logic [W-1:0]  one_out_data;
  logic [0:0]    one_out_valid;
  logic [W-1:0]  one_bus_data;
  logic          one_bus_valid;
  logic          one_conflict;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  switch_bank #(.UUID(1), .NAME("bank4"), .WIDTH(W), .CHANNELS(CH)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .en(en), .mode(mode), .clear(clear),
    .out_data(out_data), .out_valid(out_valid), .bus_data(bus_data),
    .bus_valid(bus_valid), .conflict(conflict)
  );

  switch_bank #(.UUID(2), .NAME("bank1"), .WIDTH(W), .CHANNELS(1)) u_one (
    .clk(clk), .rst(rst), .in_data(in_data[W-1:0]), .en(en[0:0]), .mode(mode), .clear(clear),
    .out_data(one_out_data), .out_valid(one_out_valid), .bus_data(one_bus_data),
    .bus_valid(one_bus_valid), .conflict(one_conflict)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per channel, updated by the rules for each mode.
  logic [W-1:0] m_data  [CH];
  bit           m_valid [CH];
  bit           m_state [CH];
  bit           m_prev  [CH];
  logic [1:0]   m_mode;

  always @(posedge clk or negedge rst) begin
    int first_en;
    bit ns;
    if (!rst) begin
      for (int k = 0; k < CH; k++) begin
        m_data[k]  <= '0;
        m_valid[k] <= 1'b0;
        m_state[k] <= 1'b0;
        m_prev[k]  <= 1'b0;
      end
      m_mode <= 2'd0;
    end else begin
      first_en = -1;
      for (int k = CH - 1; k >= 0; k--) if (en[k]) first_en = k;
      for (int k = 0; k < CH; k++) begin
        m_prev[k] <= en[k];
        if (clear || mode != m_mode) begin
          m_data[k]  <= '0;
          m_valid[k] <= 1'b0;
          m_state[k] <= 1'b0;
        end else if (mode == 2'd0) begin
          m_valid[k] <= en[k];
          m_data[k]  <= en[k] ? in_data[k*W +: W] : '0;
        end else if (mode == 2'd1) begin
          if (en[k]) begin
            m_valid[k] <= 1'b1;
            m_data[k]  <= in_data[k*W +: W];
          end
        end else if (mode == 2'd2) begin
          ns = (en[k] && !m_prev[k]) ? !m_state[k] : m_state[k];
          m_state[k] <= ns;
          m_valid[k] <= ns;
          m_data[k]  <= ns ? in_data[k*W +: W] : '0;
        end else begin
          m_valid[k] <= (k == first_en);
          m_data[k]  <= (k == first_en) ? in_data[k*W +: W] : '0;
        end
      end
      m_mode <= mode;
    end
  end

  always @(negedge clk) begin
    logic [CH*W-1:0] ed;
    logic [CH-1:0]   ev;
    logic [W-1:0]    eb;
    int              cnt;
    ed = '0; ev = '0; eb = '0; cnt = 0;
    for (int k = CH - 1; k >= 0; k--) begin
      ev[k] = m_valid[k];
      ed[k*W +: W] = m_valid[k] ? m_data[k] : '0;
      if (m_valid[k]) begin
        eb = m_data[k];
        cnt++;
      end
    end
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data", 64'(out_data), 64'(ed));
    check("bus_data", 64'(bus_data), 64'(eb));
    check("bus_valid", 64'(bus_valid), 64'(cnt >= 1));
    check("conflict", 64'(conflict), 64'(cnt >= 2));
    check("one_valid", 64'(one_out_valid), 64'(ev[0]));
    check("one_data", 64'(one_out_data), 64'(ed[W-1:0]));
    check("one_bus", 64'(one_bus_data), 64'(ed[W-1:0]));
    check("one_conflict", 64'(one_conflict), 64'(0));
  end

  task automatic drive(input logic [CH-1:0] e, input logic [1:0] m, input logic c,
                       input logic [CH*W-1:0] d);
    en = e; mode = m; clear = c; in_data = d;
    @(posedge clk);
    #1;
    $display("txn t=%0t en=%b mode=%0d clear=%0b in=%h -> valid=%b data=%h bus=%h bv=%0b cf=%0b",
             $time, e, m, c, d, out_valid, out_data, bus_data, bus_valid, conflict);
  endtask

  initial begin
    rst = 1'b1; en = '0; mode = 2'd0; clear = 1'b0; in_data = '0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_bus_valid", 64'(bus_valid), 64'h0);
    check("rst_data", 64'(out_data), 64'h0);
    rst = 1'b1;

    // GATE
    drive(4'b0101, 2'd0, 1'b0, 32'h44332211);
    check("gate_valid", 64'(out_valid), 64'b0101);
    check("gate_bus", 64'(bus_data), 64'h11);
    check("gate_conflict", 64'(conflict), 64'h1);
    check("gate_data", 64'(out_data), 64'h00330011);
    drive(4'b1000, 2'd0, 1'b0, 32'h44332211);
    check("gate_bus_hi", 64'(bus_data), 64'h44);
    check("gate_conflict_lo", 64'(conflict), 64'h0);
    drive(4'b1111, 2'd0, 1'b0, 32'hDDCCBBAA);
    drive(4'b0000, 2'd0, 1'b0, 32'hDDCCBBAA);
    check("gate_idle_bv", 64'(bus_valid), 64'h0);

    // HOLD
    drive(4'b0000, 2'd1, 1'b0, 32'h0);
    drive(4'b0001, 2'd1, 1'b0, 32'h000000A5);
    repeat (3) drive(4'b0000, 2'd1, 1'b0, 32'h000000FF);
    check("hold_data", 64'(out_data), 64'h000000A5);
    check("hold_valid", 64'(out_valid), 64'b0001);
    drive(4'b0000, 2'd1, 1'b1, 32'h000000FF);
    check("clear_valid", 64'(out_valid), 64'h0);
    check("clear_data", 64'(out_data), 64'h0);
    drive(4'b0011, 2'd1, 1'b1, 32'h00007777);
    check("clear_prio", 64'(out_valid), 64'h0);
    drive(4'b0100, 2'd1, 1'b0, 32'h00990000);

    // TOGGLE
    drive(4'b0000, 2'd2, 1'b0, 32'h0);
    check("tog_flush", 64'(out_valid), 64'h0);
    drive(4'b0010, 2'd2, 1'b0, 32'h00001000);
    check("tog_on", 64'(out_data), 64'h00001000);
    drive(4'b0010, 2'd2, 1'b0, 32'h00001100);
    drive(4'b0010, 2'd2, 1'b0, 32'h00001200);
    check("tog_held_valid", 64'(out_valid), 64'b0010);
    check("tog_held_data", 64'(out_data), 64'h00001200);
    drive(4'b0000, 2'd2, 1'b0, 32'h00002000);
    drive(4'b0000, 2'd2, 1'b0, 32'h00002100);
    check("tog_low_data", 64'(out_data), 64'h00002100);
    drive(4'b0010, 2'd2, 1'b0, 32'h00003000);
    check("tog_off", 64'(out_valid), 64'h0);
    drive(4'b0101, 2'd2, 1'b0, 32'h00550066);
    check("tog_two", 64'(out_valid), 64'b0101);

    // SOLO, then SOLO -> HOLD
    drive(4'b1110, 2'd3, 1'b0, 32'h44332211);
    check("solo_flush", 64'(out_valid), 64'h0);
    drive(4'b1110, 2'd3, 1'b0, 32'h44332211);
    check("solo_valid", 64'(out_valid), 64'b0010);
    check("solo_bus", 64'(bus_data), 64'h22);
    check("solo_conflict", 64'(conflict), 64'h0);
    drive(4'b1111, 2'd1, 1'b0, 32'h88776655);
    check("s2h_flush", 64'(out_valid), 64'h0);
    drive(4'b1111, 2'd1, 1'b0, 32'h88776655);
    check("s2h_capture", 64'(out_valid), 64'b1111);
    check("s2h_bus", 64'(bus_data), 64'h55);

    // Mid-operation reset, released with TOGGLE selected and en held high
    drive(4'b0001, 2'd1, 1'b0, 32'h0000005A);
    drive(4'b0000, 2'd1, 1'b0, 32'h0);
    check("pre_rst_hold", 64'(out_data[7:0]), 64'h5A);
    #2 rst = 1'b0;
    #1;
    check("async_valid", 64'(out_valid), 64'h0);
    check("async_data", 64'(out_data), 64'h0);
    check("async_bv", 64'(bus_valid), 64'h0);
    mode = 2'd2; en = 4'b0010; in_data = 32'h00000900;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(4'b0010, 2'd2, 1'b0, 32'h00000900);
    check("rel_flush", 64'(out_valid), 64'h0);
    drive(4'b0010, 2'd2, 1'b0, 32'h00000A00);
    check("rel_no_toggle", 64'(out_valid), 64'h0);
    drive(4'b0000, 2'd2, 1'b0, 32'h0);
    drive(4'b0010, 2'd2, 1'b0, 32'h00000B00);
    check("rel_toggle_valid", 64'(out_valid), 64'b0010);
    check("rel_toggle_data", 64'(out_data), 64'h00000B00);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
